// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;
  localparam int SUB_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// full_sub: one-bit full subtractor cell computing a - b - cin
module full_sub (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic difference,
  output logic borrow
);
  assign difference = a ^ b ^ cin;
  assign borrow = (~a & b) | (~a & cin) | (b & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin over one full_sub cell, LSB first
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         busy
);
  localparam int CW = $clog2(W);
  state_t state, state_nx;
  logic [W-1:0] a_sh, b_sh, diff_sh;
  logic [CW-1:0] cnt;
  logic brw_q, a_msb, b_msb, d, bo, fire, last;
  full_sub u_cell (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(brw_q),
    .difference(d),
    .borrow(bo)
  );
  // state register; reset wins over any handshake
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state and outputs; result fields read as zero outside DONE
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    fire      = in_valid && in_ready;
    last      = cnt == CW'(W - 1);
    out_valid = state == DONE;
    busy      = state != IDLE;
    diff      = out_valid ? diff_sh : '0;
    bout      = out_valid && brw_q;
    ovf       = out_valid && (a_msb != b_msb) && (diff_sh[W-1] != a_msb);
    state_nx  = state == IDLE ? (fire ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // operand load on accept, then one bit per cycle through the cell while running
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      cnt     <= '0;
      brw_q   <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (fire) begin
      a_sh  <= a;
      b_sh  <= b;
      brw_q <= bin;
      cnt   <= '0;
      a_msb <= a[W-1];
      b_msb <= b[W-1];
    end else if (state == RUN) begin
      diff_sh <= {d, diff_sh[W-1:1]};
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      brw_q   <= bo;
      cnt     <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that sequences a single `full_sub` cell over W-bit operands, one bit per clock, LSB first. It computes diff = a − b − bin and reports the final borrow and signed overflow. It sits between an operand producer and a result consumer using valid/ready handshakes on both sides. It trades W cycles of latency for one full-subtractor cell instead of a W-bit ripple chain.

## Interface

**Parameters**
- `W`, default 8: operand width in bits; legal range W ≥ 2.

**Ports**
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands `a`, `b`, `bin` are valid.
- `in_ready`, output, 1: the block can accept operands. A transfer occurs when `in_valid && in_ready`.
- `a`, input, W: minuend.
- `b`, input, W: subtrahend.
- `bin`, input, 1: borrow-in to bit 0.
- `out_valid`, output, 1: result fields are valid.
- `out_ready`, input, 1: consumer accepts the result. A transfer occurs when `out_valid && out_ready`.
- `diff`, output, W: result a − b − bin, modulo 2^W.
- `bout`, output, 1: borrow out of the MSB. It is 1 iff a < b + bin (unsigned).
- `ovf`, output, 1: signed (two's-complement) overflow of the subtraction.
- `busy`, output, 1: high in RUN and DONE.

## Operation

**States:** IDLE, RUN, DONE (encoded in 2 bits).

**IDLE**
- `in_ready` = 1 (forced to 0 while `rst` is high).
- On an input transfer, load registers as follows:
  - a_sh ← a
  - b_sh ← b
  - brw_q ← bin
  - cnt ← 0
  - a_msb ← a[W-1]
  - b_msb ← b[W-1]
- Then go to RUN.
- If there is no transfer, stay in IDLE.

**RUN**
- The cell inputs are a_sh[0], b_sh[0], brw_q; the cell outputs are d and bo.
- Each cycle:
  - diff_sh ← {d, diff_sh[W-1:1]}
  - a_sh and b_sh shift right by 1
  - brw_q ← bo
  - cnt ← cnt + 1
- When cnt == W−1, the current cycle processes the last bit and the state moves to DONE.
- `in_valid` is ignored in RUN; `in_ready` = 0.

**DONE**
- Outputs:
  - `out_valid` = 1
  - `diff` = diff_sh
  - `bout` = brw_q
  - `ovf` = (a_msb ≠ b_msb) && (diff_sh[W-1] ≠ a_msb)
- Outputs hold stable until `out_ready` is sampled high; then go to IDLE.
- There is no accept-while-done path; the next operand is accepted from IDLE only.

**Width rules**
- `cnt` is $clog2(W) bits wide.
- `diff` wraps modulo 2^W; the wrap is indicated by `bout`.

**Reset (synchronous, any state, including mid-RUN)**
- Next state is IDLE and any partial result is discarded.
- Reset values:
  - `out_valid` = 0, `busy` = 0
  - `diff` = 0, `bout` = 0, `ovf` = 0
  - `cnt` = 0, `brw_q` = 0
- `in_ready` is 0 during the reset cycle and 1 from the first cycle after `rst` deasserts.

**Output gating:** `diff`, `bout` and `ovf` are registered state and read as 0 outside DONE.

## Timing

- An input transfer at edge k is followed by RUN during cycles k+1 … k+W.
- `out_valid` rises after edge k+W, i.e. latency is W cycles from the accepting edge.
- With `out_ready` held high, DONE lasts 1 cycle and the block is back in IDLE after edge k+W+1. The next accept can happen at edge k+W+2, so peak throughput is one operation per W+2 cycles.
- Back-pressure: with `out_ready` low, DONE persists indefinitely with stable outputs. `in_ready` stays 0 for the whole stall.
- Simultaneous events:
  - `rst` overrides any handshake in the same cycle.
  - `in_valid` asserted in DONE in the same cycle as `out_ready` is not accepted; it must be held until IDLE.
- The `full_sub` cell is purely combinational and sits inside a single cycle path: from a_sh/b_sh/brw_q to diff_sh/brw_q.

## Structure

**Shared package `serial_sub_pkg`:**
- State enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- Default width constant SUB_W = 8.

**Sub-module:** one instance of the existing `full_sub` (a, b, cin, difference, borrow) as the datapath cell. All sequencing, shift registers and the counter live in `serial_sub_ctrl`.

## Test plan

W = 8 for all scenarios.
- a=0x05, b=0x03, bin=0 → diff=0x02, bout=0, ovf=0; `out_valid` rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Also a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Signed overflow:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0.
  - a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE → `diff`/`bout`/`ovf` stay stable and `in_ready`=0. A second `in_valid` during RUN/DONE is not accepted; it is accepted in the cycle after the IDLE return.
- Reset mid-RUN: assert `rst` at cnt=3 → next cycle state is IDLE with `out_valid`=0 and `diff`=0, and no stale result ever appears. The next operation (a=0xAA, b=0x55) gives diff=0x55, bout=0, ovf=1.
- Exhaustive-low-bits sweep: all a, b in 0..15 with bin=0/1, back-to-back with `out_ready`=1 → every result matches the reference model, with an accept spacing of exactly 10 cycles.
